// File: rtl/sseg_scan_decoder_if.sv
// Port bundle for the 7-seg scan decoder: the sampled display drive (an/sseg) and the
// reconstructed frame. The master modport is the display driver or bench, the slave is the decoder.
interface sseg_scan_decoder_if;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic [31:0] seg_frame;
  logic [15:0] hex_frame;
  logic [3:0]  hex_ok;
  logic        frame_valid;
  logic        scan_err;
  logic        stalled;

  modport master (
    output an, sseg,
    input  seg_frame, hex_frame, hex_ok, frame_valid, scan_err, stalled
  );

  modport slave (
    input  an, sseg,
    output seg_frame, hex_frame, hex_ok, frame_valid, scan_err, stalled
  );
endinterface

// File: rtl/sseg_scan_decoder.sv
// Receive side of a 4-digit multiplexed 7-seg display: captures stable digits, publishes decoded frames.
// Define SSEG_DP_CAPTURE_EN to keep the decimal point (sseg[7]) in captured bytes; otherwise it reads as off.
module sseg_scan_decoder #(
  parameter int unsigned STABLE_CYC = 16,
  parameter int unsigned STALL_CYC  = 1_000_000
) (
  input  logic               clk,
  input  logic               reset_n,
  sseg_scan_decoder_if.slave bus
);

  localparam int unsigned SCW = $clog2(STABLE_CYC + 1);
  localparam int unsigned STW = $clog2(STALL_CYC + 1);
  localparam logic [SCW-1:0] STABLE_MAX  = SCW'(STABLE_CYC);
  localparam logic [SCW-1:0] STABLE_LAST = SCW'(STABLE_CYC - 1);
  localparam logic [STW-1:0] STALL_MAX   = STW'(STALL_CYC);

  // Returns {match, nibble}; only the seven segment bits take part.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'h00;
    case (seg)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h03:   r = 5'h1B;
      7'h46:   r = 5'h1C;
      7'h21:   r = 5'h1D;
      7'h06:   r = 5'h1E;
      7'h0E:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [3:0]       an_m_q, an_s_q;
  logic [7:0]       seg_m_q, seg_s_q;
  logic [SCW-1:0]   cnt_q, cnt_d;
  logic             taken_q, taken_d;
  logic [STW-1:0]   stall_cnt_q, stall_cnt_d;
  logic             stalled_q, stalled_d;
  logic             scan_err_q, scan_err_d;
  logic [3:0]       seen_q, seen_d;
  logic [3:0][7:0]  shadow_q, shadow_d;
  logic [31:0]      seg_frame_q, seg_frame_d;
  logic [15:0]      hex_frame_q, hex_frame_d;
  logic [3:0]       hex_ok_q, hex_ok_d;
  logic             frame_valid_q, frame_valid_d;

  logic             change_c, digit_ok_c, multi_c, capture_c;
  logic [1:0]       idx_c;
  logic [7:0]       cap_byte_c;
  logic [4:0]       glyph_c;

  always_comb begin
    // Change is judged one synchroniser stage ahead so a dwell of N input cycles counts N.
    change_c      = {an_m_q, seg_m_q} != {an_s_q, seg_s_q};
    digit_ok_c    = 1'b0;
    multi_c       = 1'b0;
    idx_c         = 2'd0;
    cnt_d         = cnt_q;
    taken_d       = taken_q;
    stall_cnt_d   = stall_cnt_q;
    shadow_d      = shadow_q;
    seen_d        = seen_q;
    seg_frame_d   = seg_frame_q;
    hex_frame_d   = hex_frame_q;
    hex_ok_d      = hex_ok_q;
    frame_valid_d = 1'b0;
    glyph_c       = 5'h00;
`ifdef SSEG_DP_CAPTURE_EN
    cap_byte_c    = seg_s_q;
`else
    cap_byte_c    = {1'b1, seg_s_q[6:0]};
`endif

    case (an_s_q)
      4'b1110: begin digit_ok_c = 1'b1; idx_c = 2'd0; end
      4'b1101: begin digit_ok_c = 1'b1; idx_c = 2'd1; end
      4'b1011: begin digit_ok_c = 1'b1; idx_c = 2'd2; end
      4'b0111: begin digit_ok_c = 1'b1; idx_c = 2'd3; end
      4'b1111: digit_ok_c = 1'b0;
      default: multi_c = 1'b1;
    endcase

    capture_c = digit_ok_c && !taken_q && (cnt_q == STABLE_LAST);

    if (change_c || multi_c)        cnt_d = '0;
    else if (cnt_q != STABLE_MAX)   cnt_d = cnt_q + SCW'(1);

    if (change_c)       taken_d = 1'b0;
    else if (capture_c) taken_d = 1'b1;

    scan_err_d = scan_err_q | multi_c;

    if (capture_c)                      stall_cnt_d = '0;
    else if (stall_cnt_q != STALL_MAX)  stall_cnt_d = stall_cnt_q + STW'(1);
    stalled_d = (stall_cnt_d == STALL_MAX);

    // Commit reads the pre-capture shadows; a capture in the same cycle seeds the next frame.
    if (seen_q == 4'hF) begin
      seg_frame_d = shadow_q;
      for (int i = 0; i < 4; i++) begin
        glyph_c                = decode_glyph(shadow_q[i][6:0]);
        hex_frame_d[4*i +: 4]  = glyph_c[3:0];
        hex_ok_d[i]            = glyph_c[4];
      end
      frame_valid_d = 1'b1;
      seen_d        = '0;
    end
    if (stalled_d) seen_d = '0;
    if (capture_c) begin
      shadow_d[idx_c] = cap_byte_c;
      seen_d[idx_c]   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_m_q        <= 4'hF;
      an_s_q        <= 4'hF;
      seg_m_q       <= 8'hFF;
      seg_s_q       <= 8'hFF;
      cnt_q         <= '0;
      taken_q       <= 1'b0;
      stall_cnt_q   <= '0;
      stalled_q     <= 1'b0;
      scan_err_q    <= 1'b0;
      seen_q        <= '0;
      shadow_q      <= '1;
      seg_frame_q   <= 32'hFFFF_FFFF;
      hex_frame_q   <= '0;
      hex_ok_q      <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      an_m_q        <= bus.an;
      an_s_q        <= an_m_q;
      seg_m_q       <= bus.sseg;
      seg_s_q       <= seg_m_q;
      cnt_q         <= cnt_d;
      taken_q       <= taken_d;
      stall_cnt_q   <= stall_cnt_d;
      stalled_q     <= stalled_d;
      scan_err_q    <= scan_err_d;
      seen_q        <= seen_d;
      shadow_q      <= shadow_d;
      seg_frame_q   <= seg_frame_d;
      hex_frame_q   <= hex_frame_d;
      hex_ok_q      <= hex_ok_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign bus.seg_frame   = seg_frame_q;
  assign bus.hex_frame   = hex_frame_q;
  assign bus.hex_ok      = hex_ok_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.scan_err    = scan_err_q;
  assign bus.stalled     = stalled_q;

endmodule
